// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register specifiers, status codes
// and the write-back stage state type.
package y86_pkg;

    localparam int unsigned XLEN = 64;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    typedef enum logic {
        S_RUN,
        S_HALTED
    } wb_state_e;

    // Exception priority: address error, then illegal instruction, then halt.
    function automatic stat_e exc_stat(input logic mem_error, input logic instr_valid,
                                       input logic [3:0] icode);
        if (mem_error)           return STAT_ADR;
        else if (!instr_valid)   return STAT_INS;
        else if (icode == IHALT) return STAT_HLT;
        else                     return STAT_AOK;
    endfunction

endpackage

// File: rtl/y86_regfile.sv
// Y86-64 architectural register file: two combinational read ports, two write ports
// (M port wins on collision). Same-cycle write-to-read forwarding under WB_BYPASS_EN.
module y86_regfile #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned NREGS = 15
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [3:0]      i_src_a,
    input  logic [3:0]      i_src_b,
    output logic [XLEN-1:0] o_val_a,
    output logic [XLEN-1:0] o_val_b,
    input  logic            i_we_e,
    input  logic [3:0]      i_dst_e,
    input  logic [XLEN-1:0] i_val_e,
    input  logic            i_we_m,
    input  logic [3:0]      i_dst_m,
    input  logic [XLEN-1:0] i_val_m
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wr_e;
    logic            w_wr_m;

    assign w_wr_e = i_we_e && (32'(i_dst_e) < NREGS);
    assign w_wr_m = i_we_m && (32'(i_dst_m) < NREGS);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_wr_e) r_regs[i_dst_e] <= i_val_e;
            // Later assignment wins: popq %rsp keeps the memory value.
            if (w_wr_m) r_regs[i_dst_m] <= i_val_m;
        end
    end

    always_comb begin
        o_val_a = '0;
        o_val_b = '0;
        if (32'(i_src_a) < NREGS) o_val_a = r_regs[i_src_a];
        if (32'(i_src_b) < NREGS) o_val_b = r_regs[i_src_b];
`ifdef WB_BYPASS_EN
        if (w_wr_e && i_dst_e == i_src_a) o_val_a = i_val_e;
        if (w_wr_m && i_dst_m == i_src_a) o_val_a = i_val_m;
        if (w_wr_e && i_dst_e == i_src_b) o_val_b = i_val_e;
        if (w_wr_m && i_dst_m == i_src_b) o_val_b = i_val_m;
`endif
    end

endmodule

// File: rtl/wb_regfile_stage.sv
// Y86-64 SEQ write-back stage: destination selection, status FSM, retired count,
// wrapping y86_regfile. Define WB_BYPASS_EN for same-cycle read forwarding.
module wb_regfile_stage #(
    parameter int unsigned XLEN    = y86_pkg::XLEN,
    parameter int unsigned NREGS   = 15,
    parameter int unsigned RSP_IDX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid,
    input  logic [3:0]      icode,
    input  logic [3:0]      rA,
    input  logic [3:0]      rB,
    input  logic            cnd,
    input  logic [XLEN-1:0] valE,
    input  logic [XLEN-1:0] valM,
    input  logic            instr_valid,
    input  logic            mem_error,
    input  logic [3:0]      srcA,
    input  logic [3:0]      srcB,
    output logic [XLEN-1:0] valA,
    output logic [XLEN-1:0] valB,
    output logic [2:0]      stat,
    output logic            halted,
    output logic [63:0]     instr_count
);

    import y86_pkg::*;

    wb_state_e   r_state;
    wb_state_e   w_state_next;
    stat_e       r_stat;
    stat_e       w_exc;
    logic [63:0] r_count;
    logic [3:0]  w_dst_e;
    logic [3:0]  w_dst_m;
    logic        w_accept;
    logic        w_commit;

    always_comb begin
        w_dst_e = RNONE;
        w_dst_m = RNONE;
        case (icode)
            IRRMOVQ:                     w_dst_e = cnd ? rB : RNONE;
            IIRMOVQ, IOPQ:               w_dst_e = rB;
            ICALL, IRET, IPUSHQ, IPOPQ:  w_dst_e = 4'(RSP_IDX);
            default:                     w_dst_e = RNONE;
        endcase
        if (icode == IMRMOVQ || icode == IPOPQ) w_dst_m = rA;
    end

    assign w_exc    = exc_stat(mem_error, instr_valid, icode);
    assign w_accept = wb_valid && (r_state == S_RUN);
    assign w_commit = w_accept && (w_exc == STAT_AOK);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RUN:    if (w_accept && w_exc != STAT_AOK) w_state_next = S_HALTED;
            S_HALTED: w_state_next = S_HALTED;
            default:  w_state_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
            r_stat  <= STAT_AOK;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept && w_exc != STAT_AOK) r_stat <= w_exc;
            // A halt retires; address and instruction faults do not.
            if (w_accept && (w_exc == STAT_AOK || w_exc == STAT_HLT)) r_count <= r_count + 64'd1;
        end
    end

    y86_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_src_a (srcA),
        .i_src_b (srcB),
        .o_val_a (valA),
        .o_val_b (valB),
        .i_we_e  (w_commit && (w_dst_e != RNONE)),
        .i_dst_e (w_dst_e),
        .i_val_e (valE),
        .i_we_m  (w_commit && (w_dst_m != RNONE)),
        .i_dst_m (w_dst_m),
        .i_val_m (valM)
    );

    assign stat        = r_stat;
    assign halted      = (r_state == S_HALTED);
    assign instr_count = r_count;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Self-checking bench for wb_regfile_stage: directed steps then randomized retirement,
// checked against an architectural reference model. Honours WB_BYPASS_EN.
module tb_wb_regfile_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [3:0]  icode, rA, rB, srcA, srcB;
    logic        cnd, instr_valid, mem_error;
    logic [63:0] valE, valM, valA, valB, instr_count;
    logic [2:0]  stat;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] m_regs [15];
    int unsigned m_stat;
    logic        m_halted;
    logic [63:0] m_count;

    always #5 clk = ~clk;

    wb_regfile_stage #(.XLEN(64), .NREGS(15), .RSP_IDX(4)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .icode(icode), .rA(rA), .rB(rB),
        .cnd(cnd), .valE(valE), .valM(valM), .instr_valid(instr_valid),
        .mem_error(mem_error), .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
        .stat(stat), .halted(halted), .instr_count(instr_count)
    );

    function automatic logic [3:0] ref_dste(input logic [3:0] ic, input logic [3:0] b, input logic c);
        if (ic == 4'h3 || ic == 4'h6) return b;
        if (ic == 4'h2) return c ? b : 4'hF;
        if (ic == 4'h8 || ic == 4'h9 || ic == 4'hA || ic == 4'hB) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] ref_dstm(input logic [3:0] ic, input logic [3:0] a);
        return (ic == 4'h5 || ic == 4'hB) ? a : 4'hF;
    endfunction

    function automatic int unsigned ref_exc(input logic me, input logic iv, input logic [3:0] ic);
        if (me) return 3;
        if (!iv) return 4;
        if (ic == 4'h0) return 2;
        return 1;
    endfunction

    function automatic logic [63:0] exp_read(input logic [3:0] s);
        if (s == 4'hF) return 64'd0;
`ifdef WB_BYPASS_EN
        if (wb_valid && !m_halted && ref_exc(mem_error, instr_valid, icode) == 1) begin
            if (s == ref_dstm(icode, rA)) return valM;
            if (s == ref_dste(icode, rB, cnd)) return valE;
        end
`endif
        return m_regs[s];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, ".stat"},   64'(stat),   64'(m_stat));
        chk({tag, ".halted"}, 64'(halted), 64'(m_halted));
        chk({tag, ".count"},  instr_count, m_count);
    endtask

    task automatic do_reset(input logic v);
        @(negedge clk);
        rst = 1'b1; wb_valid = v; icode = 4'h3; rB = 4'h1; valE = 64'hBAD;
        @(posedge clk);
        foreach (m_regs[i]) m_regs[i] = 64'd0;
        m_stat = 1; m_halted = 1'b0; m_count = 64'd0;
        #1;
        rst = 1'b0; wb_valid = 1'b0;
        chk_status("reset");
    endtask

    // One cycle: drive, check reads before the edge, update the model at the edge, check status after.
    task automatic step(input string tag, input logic v, input logic [3:0] ic, ra, rb,
                        input logic c, input logic [63:0] ve, vm, input logic iv, me,
                        input logic [3:0] sa, sb);
        int unsigned e;
        logic [3:0] de, dm;
        @(negedge clk);
        wb_valid = v; icode = ic; rA = ra; rB = rb; cnd = c; valE = ve; valM = vm;
        instr_valid = iv; mem_error = me; srcA = sa; srcB = sb;
        #1;
        chk({tag, ".valA"}, valA, exp_read(sa));
        chk({tag, ".valB"}, valB, exp_read(sb));
        @(posedge clk);
        e  = ref_exc(me, iv, ic);
        de = ref_dste(ic, rb, c);
        dm = ref_dstm(ic, ra);
        if (v && !m_halted) begin
            if (e == 1) begin
                if (de != 4'hF) m_regs[de] = ve;
                if (dm != 4'hF) m_regs[dm] = vm;
                m_count = m_count + 64'd1;
            end else begin
                m_stat = e;
                m_halted = 1'b1;
                if (e == 2) m_count = m_count + 64'd1;
            end
        end
        #1;
        chk_status(tag);
        wb_valid = 1'b0;
    endtask

    task automatic idle_read(input string tag, input logic [3:0] sa, input logic [3:0] sb);
        step(tag, 1'b0, 4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, sa, sb);
    endtask

    initial begin
        rst = 1'b1; wb_valid = 1'b0; icode = 4'h1; rA = 4'hF; rB = 4'hF; cnd = 1'b0;
        valE = '0; valM = '0; instr_valid = 1'b1; mem_error = 1'b0; srcA = 4'hF; srcB = 4'hF;
        foreach (m_regs[i]) m_regs[i] = 64'd0;
        m_stat = 1; m_halted = 1'b0; m_count = 64'd0;

        do_reset(1'b1);
        for (int i = 0; i < 15; i++) idle_read("sweep", 4'(i), 4'(14 - i));
        idle_read("rnone", 4'hF, 4'hF);

        step("irmovq", 1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0, 1'b1, 1'b0, 4'h0, 4'h0);
        idle_read("irmovq_rd", 4'h0, 4'h2);
        chk("count_one", instr_count, 64'd1);

        step("cmov_nc", 1'b1, 4'h2, 4'h1, 4'h3, 1'b0, 64'd5, 64'h0, 1'b1, 1'b0, 4'h0, 4'h0);
        idle_read("cmov_nc_rd", 4'h3, 4'h2);
        step("cmov_c", 1'b1, 4'h2, 4'h1, 4'h3, 1'b1, 64'd5, 64'h0, 1'b1, 1'b0, 4'h0, 4'h0);
        idle_read("cmov_c_rd", 4'h3, 4'h2);

        step("popq_rsp", 1'b1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'hDEAD, 1'b1, 1'b0, 4'h0, 4'h0);
        idle_read("popq_rd", 4'h4, 4'h4);

        step("opq_byp", 1'b1, 4'h6, 4'hF, 4'h1, 1'b0, 64'hAA, 64'h0, 1'b1, 1'b0, 4'h1, 4'h1);
        idle_read("opq_rd", 4'h1, 4'h3);

        step("halt", 1'b1, 4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 4'h0, 4'h0);
        step("post_halt", 1'b1, 4'h3, 4'hF, 4'h1, 1'b0, 64'd7, 64'h0, 1'b1, 1'b0, 4'h1, 4'h0);
        idle_read("post_halt_rd", 4'h1, 4'h2);

        do_reset(1'b0);
        step("adr", 1'b1, 4'h3, 4'hF, 4'h5, 1'b0, 64'h55, 64'h0, 1'b1, 1'b1, 4'h5, 4'h0);
        idle_read("adr_rd", 4'h5, 4'h0);
        do_reset(1'b1);
        step("ins", 1'b1, 4'h6, 4'hF, 4'h6, 1'b0, 64'h66, 64'h0, 1'b0, 1'b0, 4'h6, 4'h0);
        do_reset(1'b1);
        for (int i = 0; i < 15; i++) idle_read("clear", 4'(i), 4'(i));

        for (int n = 0; n < 400; n++) begin
            logic [3:0] ic;
            if (m_halted && ($urandom % 4 == 0)) do_reset(1'($urandom));
            ic = ($urandom % 40 == 0) ? 4'h0 : 4'($urandom_range(1, 11));
            step("rand", 1'($urandom % 5 != 0), ic, 4'($urandom), 4'($urandom), 1'($urandom),
                 {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom % 30 != 0),
                 1'($urandom % 40 == 0), 4'($urandom), 4'($urandom));
        end
        for (int i = 0; i < 15; i++) idle_read("final", 4'(i), 4'(14 - i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
